// File: rtl/vga_timing_pkg.sv
// Shared 1024x768@60 raster constants and the lock-qualification FSM state type.
package vga_timing_pkg;

  localparam int unsigned XGA_H_ACTIVE = 1024;
  localparam int unsigned XGA_H_FP     = 24;
  localparam int unsigned XGA_H_SYNC   = 136;
  localparam int unsigned XGA_H_BP     = 160;
  localparam int unsigned XGA_H_TOTAL  = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;

  localparam int unsigned XGA_V_ACTIVE = 768;
  localparam int unsigned XGA_V_FP     = 3;
  localparam int unsigned XGA_V_SYNC   = 6;
  localparam int unsigned XGA_V_BP     = 29;
  localparam int unsigned XGA_V_TOTAL  = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;

  localparam int unsigned XGA_HW        = 11;
  localparam int unsigned XGA_VW        = 10;
  localparam int unsigned XGA_LOCK_WAIT = 1024;

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_e;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Registered raster outputs of the timing generator, grouped for downstream video logic.
interface vga_timing_gen_if #(
  parameter int unsigned HW = 11,
  parameter int unsigned VW = 10
);
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [HW-1:0] x;
  logic [VW-1:0] y;
  logic          line_start;
  logic          frame_start;
  logic          running;

  modport master (
    output hsync, vsync, de, x, y, line_start, frame_start, running
  );

  modport slave (
    input hsync, vsync, de, x, y, line_start, frame_start, running
  );
endinterface

// File: rtl/lock_filter.sv
// Synchronizes PLL lock and only declares RUN once it has been stable for LOCK_WAIT cycles.
module lock_filter
  import vga_timing_pkg::*;
#(
  parameter int unsigned LOCK_WAIT = XGA_LOCK_WAIT
) (
  input  logic clkin,
  input  logic reset,
  input  logic lock,
  output logic running,
  output logic cnt_en
);

  localparam int unsigned CW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_WAIT - 1);

  logic          lock_meta_q, lock_s_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        if (!lock_s_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
    end else begin
      lock_meta_q <= lock;
      lock_s_q    <= lock_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
  end

  assign running = (state_q == RUN);
  // Counters advance only while RUN persists into the next cycle, so an exit clears them.
  assign cnt_en  = running & lock_s_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, sync/DE decode and registered outputs, gated by the lock filter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = XGA_H_ACTIVE,
  parameter int unsigned H_FP      = XGA_H_FP,
  parameter int unsigned H_SYNC    = XGA_H_SYNC,
  parameter int unsigned H_BP      = XGA_H_BP,
  parameter int unsigned V_ACTIVE  = XGA_V_ACTIVE,
  parameter int unsigned V_FP      = XGA_V_FP,
  parameter int unsigned V_SYNC    = XGA_V_SYNC,
  parameter int unsigned V_BP      = XGA_V_BP,
  parameter int unsigned HW        = XGA_HW,
  parameter int unsigned VW        = XGA_VW,
  parameter int unsigned LOCK_WAIT = XGA_LOCK_WAIT
) (
  input logic              clkin,
  input logic              reset,
  input logic              lock,
  vga_timing_gen_if.master vid
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((64'd1 << HW) < 64'(H_TOTAL)) begin : g_bad_hw
    $error("HW too narrow to hold H_TOTAL-1");
  end
  if ((64'd1 << VW) < 64'(V_TOTAL)) begin : g_bad_vw
    $error("VW too narrow to hold V_TOTAL-1");
  end

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_DE_END   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_DE_END   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic          running, cnt_en;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          de_c, hs_act, vs_act;
  logic          hsync_q, vsync_q, de_q, line_start_q, frame_start_q;
  logic [HW-1:0] x_q;
  logic [VW-1:0] y_q;

  lock_filter #(
    .LOCK_WAIT (LOCK_WAIT)
  ) u_lock_filter (
    .clkin   (clkin),
    .reset   (reset),
    .lock    (lock),
    .running (running),
    .cnt_en  (cnt_en)
  );

  always_comb begin
    h_d = '0;
    v_d = '0;
    if (cnt_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
        v_d = v_q;
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign de_c   = (h_q < H_DE_END) && (v_q < V_DE_END);
  assign hs_act = (h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END);
  assign vs_act = (v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END);

  // Outputs lag the counters by one cycle; outside RUN they load idle values.
  always_ff @(posedge clkin) begin
    if (reset || !running) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= ~hs_act;
      vsync_q       <= ~vs_act;
      de_q          <= de_c;
      x_q           <= de_c ? h_q : '0;
      y_q           <= de_c ? v_q : '0;
      line_start_q  <= (h_q == '0);
      frame_start_q <= (h_q == '0) && (v_q == '0);
    end
  end

  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.de          = de_q;
  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;
  assign vid.running     = running;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster, checked against a position-based reference model.
module tb_vga_timing_gen;

  localparam int HA = 16, HFP = 2, HS = 3, HBP = 4;
  localparam int VA = 8, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int LW = 16;
  localparam int HWB = 5, VWB = 4;
  localparam logic [14:0] IDLE = {1'b1, 1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic lock = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  vga_timing_gen_if #(.HW(HWB), .VW(VWB)) vif ();

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .HW (HWB), .VW (VWB), .LOCK_WAIT (LW)
  ) dut (
    .clkin (clk),
    .reset (reset),
    .lock  (lock),
    .vid   (vif)
  );

  always #5 clk = ~clk;

  logic [14:0] obs, expv;
  assign obs = {vif.hsync, vif.vsync, vif.de, vif.x, vif.y, vif.line_start, vif.frame_start,
                vif.running};

  // Reference model: raster position is a single index into the frame since RUN began.
  bit         m_run;
  int         m_pos, m_stable, mh, mv;
  bit   [1:0] m_sync;
  logic       e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_ls = 1'b0, e_fs = 1'b0;
  logic [4:0] e_x = '0;
  logic [3:0] e_y = '0;
  assign expv = {e_hs, e_vs, e_de, e_x, e_y, e_ls, e_fs, m_run};

  always @(posedge clk) begin
    if (reset) begin
      m_sync = 2'b00; m_stable = 0; m_run = 0; m_pos = 0;
      e_hs = 1; e_vs = 1; e_de = 0; e_x = 0; e_y = 0; e_ls = 0; e_fs = 0;
    end else begin
      mh = m_pos % HT;
      mv = m_pos / HT;
      if (m_run) begin
        e_de = (mh < HA) && (mv < VA);
        e_hs = !((mh >= HA + HFP) && (mh < HA + HFP + HS));
        e_vs = !((mv >= VA + VFP) && (mv < VA + VFP + VS));
        e_x  = e_de ? mh[4:0] : 5'd0;
        e_y  = e_de ? mv[3:0] : 4'd0;
        e_ls = (mh == 0);
        e_fs = (m_pos == 0);
      end else begin
        e_hs = 1; e_vs = 1; e_de = 0; e_x = 0; e_y = 0; e_ls = 0; e_fs = 0;
      end
      if (!m_run) begin
        m_stable = m_sync[1] ? m_stable + 1 : 0;
        if (m_stable == LW) begin
          m_run = 1; m_pos = 0; m_stable = 0;
        end
      end else if (!m_sync[1]) begin
        m_run = 0; m_pos = 0; m_stable = 0;
      end else begin
        m_pos = (m_pos + 1) % FRAME;
      end
      m_sync = {m_sync[0], lock};
    end
  end

  task automatic test_reset();
    int cyc;
    reset = 1; lock = 1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs !== IDLE) begin
      n_err++; $display("FAIL reset_idle got=%h want=%h", obs, IDLE);
    end
    reset = 0;
    for (cyc = 1; cyc <= LW + 40; cyc++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== expv) begin
        n_err++; $display("FAIL reset_model t=%0t got=%h want=%h", $time, obs, expv);
      end
      if (vif.running) break;
    end
    n_cmp++;
    if (cyc !== 2 + LW) begin
      n_err++; $display("FAIL lock_to_running got=%0d want=%0d", cyc, 2 + LW);
    end
    @(negedge clk);
    n_cmp++;
    if ({vif.frame_start, vif.line_start, vif.de, vif.x, vif.y} !== {3'b111, 5'd0, 4'd0}) begin
      n_err++;
      $display("FAIL first_pixel got fs=%b ls=%b de=%b x=%0d y=%0d want fs=1 ls=1 de=1 x=0 y=0",
               vif.frame_start, vif.line_start, vif.de, vif.x, vif.y);
    end
  endtask

  task automatic test_glitch();
    int cyc;
    @(negedge clk); reset = 1; lock = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (LW / 2) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== expv) begin
        n_err++; $display("FAIL glitch_pre t=%0t got=%h want=%h", $time, obs, expv);
      end
    end
    lock = 0;
    @(negedge clk);
    lock = 1;
    for (cyc = 1; cyc <= LW + 40; cyc++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== expv) begin
        n_err++; $display("FAIL glitch_model t=%0t got=%h want=%h", $time, obs, expv);
      end
      if (vif.running) break;
    end
    n_cmp++;
    if (cyc !== 2 + LW) begin
      n_err++; $display("FAIL glitch_requalify got=%0d want=%0d", cyc, 2 + LW);
    end
  endtask

  task automatic test_random_lock();
    int hi, lo;
    for (int it = 0; it < 14; it++) begin
      hi = $urandom_range(LW + 8, 1);
      lo = $urandom_range(3, 1);
      for (int c = 0; c < hi + lo; c++) begin
        lock = (c < hi);
        @(negedge clk);
        n_cmp++;
        if (obs !== expv) begin
          n_err++; $display("FAIL random_lock t=%0t got=%h want=%h", $time, obs, expv);
        end
      end
    end
    lock = 1;
  endtask

  task automatic test_free_run();
    int i, t, last_fs, last_ls, de_cnt, hs_low, hs_first, vs_low, vs_first, max_x, max_y;
    lock = 1;
    for (i = 0; i < FRAME + LW + 10; i++) begin
      @(negedge clk);
      if (vif.frame_start) break;
    end
    n_cmp++;
    if (!vif.frame_start) begin
      n_err++; $display("FAIL free_run_start got=0 want=frame_start");
    end
    last_fs = 0; last_ls = 0; de_cnt = 0; hs_low = 0; hs_first = -1;
    vs_low = 0; vs_first = -1; max_x = 0; max_y = 0;
    for (t = 0; t <= 2 * FRAME; t++) begin
      if (t > 0) @(negedge clk);
      n_cmp++;
      if (obs !== expv) begin
        n_err++; $display("FAIL free_run_model t=%0t got=%h want=%h", $time, obs, expv);
      end
      if (t > 0 && vif.line_start) begin
        n_cmp++;
        if (t - last_ls !== HT || hs_low !== HS || hs_first !== HA + HFP) begin
          n_err++;
          $display("FAIL line_timing got period=%0d hs_low=%0d hs_at=%0d want %0d/%0d/%0d",
                   t - last_ls, hs_low, hs_first, HT, HS, HA + HFP);
        end
        last_ls = t; hs_low = 0; hs_first = -1;
      end
      if (t > 0 && vif.frame_start) begin
        n_cmp++;
        if (t - last_fs !== FRAME || de_cnt !== HA * VA) begin
          n_err++;
          $display("FAIL frame_timing got period=%0d de=%0d want %0d/%0d",
                   t - last_fs, de_cnt, FRAME, HA * VA);
        end
        n_cmp++;
        if (vs_low !== VS * HT || vs_first !== (VA + VFP) * HT) begin
          n_err++;
          $display("FAIL vsync_timing got low=%0d at=%0d want %0d/%0d",
                   vs_low, vs_first, VS * HT, (VA + VFP) * HT);
        end
        n_cmp++;
        if (max_x !== HA - 1 || max_y !== VA - 1) begin
          n_err++;
          $display("FAIL xy_sweep got x=%0d y=%0d want %0d/%0d", max_x, max_y, HA - 1, VA - 1);
        end
        last_fs = t; de_cnt = 0; vs_low = 0; vs_first = -1; max_x = 0; max_y = 0;
      end
      if (!vif.hsync) begin
        hs_low++;
        if (hs_first < 0) hs_first = t - last_ls;
      end
      if (!vif.vsync) begin
        vs_low++;
        if (vs_first < 0) vs_first = t - last_fs;
      end
      if (vif.de) begin
        de_cnt++;
        if (int'(vif.x) > max_x) max_x = int'(vif.x);
        if (int'(vif.y) > max_y) max_y = int'(vif.y);
      end else begin
        n_cmp++;
        if (vif.x !== '0 || vif.y !== '0) begin
          n_err++; $display("FAIL xy_blank got x=%0d y=%0d want 0/0", vif.x, vif.y);
        end
      end
    end
  endtask

  task automatic test_lock_drop();
    int i, cyc;
    for (i = 0; i < FRAME + LW + 10; i++) begin
      @(negedge clk);
      if (vif.de && vif.x == 5'd10 && vif.y == 4'd5) break;
    end
    n_cmp++;
    if (!(vif.de && vif.x == 5'd10 && vif.y == 4'd5)) begin
      n_err++; $display("FAIL drop_point got x=%0d y=%0d want 10/5", vif.x, vif.y);
    end
    lock = 0;
    for (cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== expv) begin
        n_err++; $display("FAIL drop_model t=%0t got=%h want=%h", $time, obs, expv);
      end
      if (obs === IDLE) break;
    end
    n_cmp++;
    if (cyc !== 4) begin
      n_err++; $display("FAIL drop_to_idle got=%0d want=4", cyc);
    end
    repeat (3) @(negedge clk);
    lock = 1;
    for (cyc = 1; cyc <= LW + 20; cyc++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== expv) begin
        n_err++; $display("FAIL relock_model t=%0t got=%h want=%h", $time, obs, expv);
      end
      if (vif.frame_start) break;
    end
    n_cmp++;
    if (cyc !== LW + 3 || vif.x !== '0 || vif.y !== '0 || !vif.de) begin
      n_err++;
      $display("FAIL relock_frame got cyc=%0d x=%0d y=%0d de=%b want %0d/0/0/1",
               cyc, vif.x, vif.y, vif.de, LW + 3);
    end
  endtask

  task automatic test_reset_mid();
    int i, cyc;
    for (i = 0; i < FRAME + LW + 10; i++) begin
      @(negedge clk);
      if (m_run && m_pos == (VA + VFP + 1) * HT + HA + HFP + 1) break;
    end
    n_cmp++;
    if (vif.hsync !== 1'b0 || vif.vsync !== 1'b0) begin
      n_err++; $display("FAIL mid_sync got hs=%b vs=%b want 0/0", vif.hsync, vif.vsync);
    end
    reset = 1;
    @(negedge clk);
    reset = 0;
    n_cmp++;
    if ({vif.hsync, vif.vsync, vif.de, vif.running} !== 4'b1100) begin
      n_err++;
      $display("FAIL reset_mid_idle got hs=%b vs=%b de=%b run=%b want 1/1/0/0",
               vif.hsync, vif.vsync, vif.de, vif.running);
    end
    for (cyc = 1; cyc <= LW + 40; cyc++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== expv) begin
        n_err++; $display("FAIL reset_mid_model t=%0t got=%h want=%h", $time, obs, expv);
      end
      if (vif.running) break;
    end
    n_cmp++;
    if (cyc !== 2 + LW) begin
      n_err++; $display("FAIL reset_mid_requalify got=%0d want=%0d", cyc, 2 + LW);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_random_lock();
    test_free_run();
    test_lock_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
